pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised N-stage pipeline register chain with per-stage valid bits and a valid/ready handshake on both ends. It is the flow-controlled successor to the plain enable-gated flip-flop delay line. It supports synchronous flush, an occupancy count, and a build-time choice between bubble-collapsing (elastic) and lockstep (global-stall) advancement. Its job is to carry pipeline payloads (instruction/operand bundles, memory responses) across a fixed number of cycles while tolerating downstream stalls.

## Interface
- N, 3: number of register stages, N >= 1.
- WIDTH, 1: payload width in bits.
- RESET_VALUE, 0: reset value of every data register.
- COLLAPSE, 1: 1 = bubble-collapsing advance; 0 = lockstep advance with global stall.

- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  chain accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage N-1 holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  stage N-1 payload.
- count  output  $clog2(N+1)  number of valid stages, registered.

## Operation
- Storage per stage k (0 = input end, N-1 = output end):
  - valid_k: flop reset to 0.
  - data_k: flop reset to RESET_VALUE, written only when the stage loads, held otherwise.
- Outputs: out_valid = valid_{N-1} and out_data = data_{N-1}, except during flush (see below).
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- COLLAPSE=1 advance rules (combinational ripple from the output end):
  - move_{N-1} = valid_{N-1} && out_ready.
  - move_k = valid_k && (!valid_{k+1} || move_{k+1}).
  - in_ready = !valid_0 || move_0.
  - load_0 = in_valid && in_ready; load_k = move_{k-1}.
  - valid_k next = load_k || (valid_k && !move_k).
  - Effect: bubbles are squeezed out, so all N stages can fill under backpressure.
- COLLAPSE=0 advance rules:
  - adv = !valid_{N-1} || out_ready; in_ready = adv.
  - On adv, every stage shifts one place: valid_0 <= in_valid, data_0 <= in_data; valid/data_k <= valid/data_{k-1}.
  - Bubbles travel with the chain. The chain stalls whenever the output stalls, even if it contains bubbles.
  - data_0 loads only when in_valid && adv.
- flush (priority over everything except reset):
  - In the flush cycle, in_ready = 0 and out_valid = 0, so no transfer occurs on either side.
  - At the next edge, all valid_k <= 0 and count <= 0. Data registers hold.
- count next = popcount of valid next. It is 0 after reset or flush and never exceeds N.
- Output stability: while out_valid && !out_ready and flush = 0, out_valid and out_data hold unchanged.
- N = 1: a single stage; in_ready = !valid_0 || out_ready (both modes reduce to this).

## Timing
- Reset behaviour: while reset is high, regardless of clk:
  - all valid_k = 0, all data_k = RESET_VALUE, count = 0;
  - out_valid = 0, out_data = RESET_VALUE, in_ready = 0.
  - Reset asserted mid-stream discards all payloads immediately.
  - in_ready rises combinationally after reset deasserts.
- Latency: a payload accepted at the edge ending cycle c is presented on out_data in cycle c+N, provided no stall occurs.
- Throughput: 1 payload/cycle in both modes when out_ready = 1. This holds with a full chain and simultaneous input and output transfers.
- in_ready depends combinationally on out_ready (ripple path through N stages in COLLAPSE=1). out_valid and out_data are register outputs, gated only by flush.
- A simultaneous flush and input/output request results in no transfer. An edge where reset and flush are both high results in reset state.

## Test plan
- Streaming: N=3, WIDTH=8, out_ready=1; present 0x11, 0x22, 0x33 in cycles 0-2 -> out_valid=1 with 0x11, 0x22, 0x33 in cycles 3-5; in_ready=1 throughout; count peaks at 3.
- Collapse under backpressure: COLLAPSE=1, out_ready=0; offer A1 in c0, idle in c1, then A2, A3, A4 from c2 -> A1..A3 accepted; in_ready=0 in c4 with count=3. Raise out_ready in c5 -> A1, A2, A3 output in c5-c7; A4 accepted in c5.
- Lockstep bubble: COLLAPSE=0, same stimulus -> A1 and A2 accepted; in_ready=0 from c3 with count=2; bubble retained between A1 and A2 at the output end.
- Flush: full chain, out_ready=0; flush=1 for one cycle with in_valid=1 -> in_ready=0 and out_valid=0 in that cycle; next cycle count=0, out_valid=0; in_data not captured.
- Async reset mid-stream: load 3 payloads, then assert reset between clock edges -> out_valid=0, out_data=RESET_VALUE, count=0, in_ready=0 immediately. After release, 0x5A is accepted and output N cycles later.
- N=1 degenerate: out_ready toggling 1,0,1 with a continuous input stream -> in_ready follows !valid_0 || out_ready; no payload lost or duplicated.

Source files
------------

// File: rtl/pipe_chain.sv
// pipe_chain: N-stage valid/ready register chain.
// Supports a synchronous flush, a registered occupancy count and a build-time
// choice between bubble-collapsing (elastic) and lockstep (global-stall) advance.
module pipe_chain #(
    parameter int               N           = 3,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit               COLLAPSE    = 1'b1,
    localparam int              CW          = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [N-1:0]     valid_r;
    logic [WIDTH-1:0] data_r [N];
    logic [CW-1:0]    count_r;

    logic [N-1:0]     valid_nxt_s;
    logic [N-1:0]     load_s;
    logic             ready_s;

    // Number of set bits in a stage-valid vector.
    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    generate
        if (COLLAPSE) begin : g_collapse
            logic [N-1:0] move_s;

            // Elastic advance: a stage moves when its successor is empty or
            // itself moving, rippling back from the output end.
            always_comb begin
                move_s      = {N{1'b0}};
                load_s      = {N{1'b0}};
                valid_nxt_s = {N{1'b0}};
                move_s[N-1] = valid_r[N-1] && out_ready && !flush;
                for (int k = N - 2; k >= 0; k--) begin
                    move_s[k] = valid_r[k] && (!valid_r[k+1] || move_s[k+1]);
                end
                ready_s   = !reset && !flush && (!valid_r[0] || move_s[0]);
                load_s[0] = in_valid && ready_s;
                for (int k = 1; k < N; k++) begin
                    load_s[k] = move_s[k-1];
                end
                valid_nxt_s = load_s | (valid_r & ~move_s);
            end
        end else begin : g_lockstep
            logic adv_s;

            // Lockstep advance: the whole chain shifts together, bubbles included,
            // and stalls as a unit whenever the output end is blocked.
            always_comb begin
                load_s         = {N{1'b0}};
                valid_nxt_s    = valid_r;
                adv_s          = !valid_r[N-1] || out_ready;
                ready_s        = !reset && !flush && adv_s;
                load_s[0]      = in_valid && ready_s;
                valid_nxt_s[0] = adv_s ? in_valid : valid_r[0];
                for (int k = 1; k < N; k++) begin
                    load_s[k]      = adv_s && !flush;
                    valid_nxt_s[k] = adv_s ? valid_r[k-1] : valid_r[k];
                end
            end
        end
    endgenerate

    // Stage valid/data and occupancy registers; flush clears valids but keeps data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= {N{1'b0}};
            count_r <= {CW{1'b0}};
            for (int k = 0; k < N; k++) begin
                data_r[k] <= RESET_VALUE;
            end
        end else if (flush) begin
            valid_r <= {N{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            count_r <= popcount(valid_nxt_s);
            if (load_s[0]) begin
                data_r[0] <= in_data;
            end
            for (int k = 1; k < N; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= data_r[k-1];
                end
            end
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = valid_r[N-1] && !flush;
    assign out_data  = data_r[N-1];
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: three instances (N=3 elastic, N=3 lockstep, N=1 elastic)
// compared each cycle against an item-level reference model.
module tb_pipe_chain;

    localparam logic [7:0] RV = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       fl  [3];
    logic       iv  [3];
    logic       orr [3];
    logic [7:0] id  [3];
    logic       ir  [3];
    logic       ovl [3];
    logic [7:0] od  [3];
    logic [1:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;
    logic [1:0] oc  [3];

    assign oc[0] = cnt_a;
    assign oc[1] = cnt_b;
    assign oc[2] = {1'b0, cnt_c};

    pipe_chain #(.N(3), .WIDTH(8), .RESET_VALUE(RV), .COLLAPSE(1'b1)) u_a (
        .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ovl[0]), .out_ready(orr[0]), .out_data(od[0]), .count(cnt_a));
    pipe_chain #(.N(3), .WIDTH(8), .RESET_VALUE(RV), .COLLAPSE(1'b0)) u_b (
        .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ovl[1]), .out_ready(orr[1]), .out_data(od[1]), .count(cnt_b));
    pipe_chain #(.N(1), .WIDTH(8), .RESET_VALUE(RV), .COLLAPSE(1'b1)) u_c (
        .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ovl[2]), .out_ready(orr[2]), .out_data(od[2]), .count(cnt_c));

    // Reference model: which stages hold an item, and which item.
    int         mn [3] = '{3, 3, 1};
    bit         mc [3] = '{1'b1, 1'b0, 1'b1};
    bit         mv [3][3];
    logic [7:0] md [3][3];

    int total = 0;
    int bad   = 0;

    function automatic int m_count(input int i);
        int c = 0;
        for (int k = 0; k < mn[i]; k++) c += int'(mv[i][k]);
        return c;
    endfunction

    // Elastic: accepts unless every stage is full and the output is stalled.
    // Lockstep: accepts only when the output end can move.
    function automatic bit m_ready(input int i);
        if (reset || fl[i]) return 1'b0;
        if (mc[i]) return orr[i] || (m_count(i) < mn[i]);
        return !mv[i][mn[i]-1] || orr[i];
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) mv[i][k] = 1'b0;
    endtask

    task automatic check_all();
        int  n;
        bit  er, ev;
        for (int i = 0; i < 3; i++) begin
            n  = mn[i];
            er = m_ready(i);
            ev = !reset && !fl[i] && mv[i][n-1];
            chk($sformatf("in_ready[%0d]", i), {7'd0, ir[i]}, {7'd0, er});
            chk($sformatf("out_valid[%0d]", i), {7'd0, ovl[i]}, {7'd0, ev});
            chk($sformatf("count[%0d]", i), {6'd0, oc[i]}, 8'(m_count(i)));
            if (ev) chk($sformatf("out_data[%0d]", i), od[i], md[i][n-1]);
            if (reset) chk($sformatf("reset_data[%0d]", i), od[i], RV);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int         n;
        bit         fin, room;
        bit         nv [3];
        logic [7:0] nd [3];
        for (int i = 0; i < 3; i++) begin
            n   = mn[i];
            fin = iv[i] && m_ready(i);
            for (int k = 0; k < 3; k++) begin
                nv[k] = 1'b0;
                nd[k] = md[i][k];
            end
            if (reset || fl[i]) begin
                // everything dropped
            end else if (mc[i]) begin
                for (int k = n - 1; k >= 0; k--) begin
                    if (mv[i][k]) begin
                        room = orr[i];
                        for (int j = k + 1; j < n; j++) if (!mv[i][j]) room = 1'b1;
                        if (!room) begin
                            nv[k] = 1'b1;
                            nd[k] = md[i][k];
                        end else if (k < n - 1) begin
                            nv[k+1] = 1'b1;
                            nd[k+1] = md[i][k];
                        end
                    end
                end
                if (fin) begin
                    nv[0] = 1'b1;
                    nd[0] = id[i];
                end
            end else begin
                if (!mv[i][n-1] || orr[i]) begin
                    for (int k = n - 1; k >= 1; k--) begin
                        nv[k] = mv[i][k-1];
                        nd[k] = md[i][k-1];
                    end
                    nv[0] = iv[i];
                    if (iv[i]) nd[0] = id[i];
                end else begin
                    for (int k = 0; k < n; k++) nv[k] = mv[i][k];
                end
            end
            for (int k = 0; k < 3; k++) begin
                mv[i][k] = nv[k];
                md[i][k] = nd[k];
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input int i, input bit v, input logic [7:0] d, input bit r, input bit f);
        iv[i]  = v;
        id[i]  = d;
        orr[i] = r;
        fl[i]  = f;
    endtask

    task automatic drive_rand(input int i);
        drive(i, 1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(15) == 0);
    endtask

    logic [7:0] sv  [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] itm [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int         idx [2];
    bit         acc [2];

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
        model_clear();
        #2;
        check_all();
        step();
        step();
        reset = 1'b0;

        // Streaming on A/B; N=1 instance C with a continuous stream and toggling out_ready.
        for (int c = 0; c < 8; c++) begin
            drive(0, c < 3, (c < 3) ? sv[c] : 8'h00, 1'b1, 1'b0);
            drive(1, c < 3, (c < 3) ? sv[c] : 8'h00, 1'b1, 1'b0);
            drive(2, 1'b1, 8'(8'h40 + c), (c % 3) != 1, 1'b0);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stream_data", od[0], sv[c-3]);
                chk("stream_valid", {7'd0, ovl[0]}, 8'h01);
            end
            step();
        end

        // Backpressure scenario: A1, idle, A2.. offered; out_ready raised in c5.
        idx[0] = 0;
        idx[1] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++)
                drive(i, (c != 1) && (idx[i] < 4), itm[(idx[i] < 4) ? idx[i] : 3], c >= 5, 1'b0);
            drive_rand(2);
            #1;
            if (c == 3) chk("lock_ready_c3", {7'd0, ir[1]}, 8'h00);
            if (c == 4) begin
                chk("coll_ready_c4", {7'd0, ir[0]}, 8'h00);
                chk("coll_count_c4", {6'd0, cnt_a}, 8'h03);
                chk("lock_count_c4", {6'd0, cnt_b}, 8'h02);
                chk("lock_ready_c4", {7'd0, ir[1]}, 8'h00);
            end
            if (c == 5) chk("coll_out_c5", od[0], 8'hA1);
            for (int i = 0; i < 2; i++) acc[i] = iv[i] && m_ready(i);
            step();
            for (int i = 0; i < 2; i++) if (acc[i]) idx[i]++;
        end

        // Flush a full, stalled chain while input is offered.
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 8'(8'h60 + c), 1'b0, 1'b0);
            drive(1, 1'b1, 8'(8'h70 + c), 1'b0, 1'b0);
            drive_rand(2);
            step();
        end
        drive(0, 1'b1, 8'hEE, 1'b0, 1'b1);
        drive(1, 1'b1, 8'hEE, 1'b0, 1'b1);
        #1;
        chk("flush_ready", {7'd0, ir[0]}, 8'h00);
        chk("flush_valid", {7'd0, ovl[0]}, 8'h00);
        step();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        chk("post_flush_count", {6'd0, cnt_a}, 8'h00);
        chk("post_flush_valid", {7'd0, ovl[0]}, 8'h00);
        for (int c = 0; c < 4; c++) step();

        // Asynchronous reset between edges with a loaded chain.
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, 8'(8'h80 + c), 1'b0, 1'b0);
            drive(1, 1'b1, 8'(8'h90 + c), 1'b0, 1'b0);
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_rst_data", od[0], RV);
        chk("async_rst_valid", {7'd0, ovl[0]}, 8'h00);
        chk("async_rst_ready", {7'd0, ir[0]}, 8'h00);
        check_all();
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(0, c == 0, 8'h5A, 1'b1, 1'b0);
            drive(1, c == 0, 8'h5A, 1'b1, 1'b0);
            drive(2, c == 0, 8'h5A, 1'b1, 1'b0);
            #1;
            if (c == 3) begin
                chk("rst_then_5a_valid", {7'd0, ovl[0]}, 8'h01);
                chk("rst_then_5a_data", od[0], 8'h5A);
            end
            step();
        end

        // Randomized traffic on all three instances.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) drive_rand(i);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
